// File: rtl/exp_arb_pkg.sv
// exp_arb_pkg: shared state encoding and default widths for the exponential-core arbiter
package exp_arb_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, ARM, WAIT, RESP} arb_state_t;
    localparam int XW_D = 16;
    localparam int RW_D = 18;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: round-robin winner search, first set request at or after ptr with wrap
module rr_picker #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] winner
);
    logic [2*N-1:0] dbl;
    always_comb begin
        // the upper copy supplies the wrapped-around candidates below ptr
        dbl = {req, req} & ~((2*N)'((1 << ptr) - 1));
        winner = '0;
        for (int i = 2*N-1; i >= 0; i--)
            if (dbl[i]) winner = IW'(i % N);
        any = |req;
    end
endmodule

// File: rtl/exp_arbiter.sv
// exp_arbiter: shares one exponential core among N requesters in round-robin order,
// sequencing start/done and flagging jobs whose core never completes
module exp_arbiter
    import exp_arb_pkg::*;
#(
    parameter  int N   = 4,
    parameter  int XW  = XW_D,
    parameter  int RW  = RW_D,
    parameter  int TMO = 1023,
    localparam int IW  = $clog2(N),
    localparam int TW  = $clog2(TMO + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*XW-1:0] req_x,
    output logic [N-1:0]    resp_valid,
    output logic [RW-1:0]   resp_data,
    output logic            resp_err,
    output logic            busy,
    output logic [IW-1:0]   grant_id,
    output logic            exp_start,
    output logic [XW-1:0]   exp_x,
    input  logic            exp_done,
    input  logic [RW-1:0]   exp_result
);
    arb_state_t    state_q;
    logic [IW-1:0] ptr_q, grant_q, winner;
    logic [XW-1:0] x_q;
    logic [TW-1:0] tmo_q;
    logic [RW-1:0] data_q;
    logic [N-1:0]  valid_q;
    logic          err_q, start_q, any;

    rr_picker #(.N(N)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (any),
        .winner (winner)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            x_q     <= '0;
            tmo_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            valid_q <= '0;
            start_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (any) begin
                    grant_q <= winner;
                    x_q     <= req_x[winner*XW +: XW];
                    start_q <= 1'b1;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    start_q <= 1'b0;
                    state_q <= ARM;
                end
                // done is still high from the previous idle period until the core samples start
                ARM: begin
                    tmo_q   <= '0;
                    state_q <= WAIT;
                end
                WAIT: if (exp_done) begin
                    data_q  <= exp_result;
                    err_q   <= 1'b0;
                    valid_q <= N'(1) << grant_q;
                    state_q <= RESP;
                end else if (tmo_q == TW'(TMO)) begin
                    data_q  <= '0;
                    err_q   <= 1'b1;
                    valid_q <= N'(1) << grant_q;
                    state_q <= RESP;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
                RESP: begin
                    valid_q <= '0;
                    ptr_q   <= grant_q == IW'(N - 1) ? '0 : grant_q + 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign resp_valid = valid_q;
    assign resp_data  = data_q;
    assign resp_err   = err_q;
    assign busy       = state_q != IDLE;
    assign grant_id   = grant_q;
    assign exp_start  = start_q;
    assign exp_x      = x_q;
endmodule

// File: tb/tb_exp_arbiter.sv
// tb_exp_arbiter: randomized scoreboard bench for exp_arbiter with a behavioural core model
module tb_exp_arbiter;
    localparam int N = 4, XW = 16, RW = 18, TMO = 15, IW = 2;

    logic clk = 0, rst = 0;
    logic [N-1:0] req = '0;
    logic [N*XW-1:0] req_x = '0;
    logic [N-1:0] resp_valid;
    logic [RW-1:0] resp_data;
    logic resp_err, busy, exp_start;
    logic [IW-1:0] grant_id;
    logic [XW-1:0] exp_x;
    logic exp_done = 1'b1;
    logic [RW-1:0] exp_result = '0;

    typedef struct {
        int id;
        logic [XW-1:0] x;
        logic [RW-1:0] data;
        logic err;
    } exp_t;

    exp_t sb[$];
    int passed = 0, total = 0;
    int cyc = 0, start_cyc = 0, core_lat = 0, ptr_m = 0;
    int n_start = 0, n_resp = 0;
    bit hang = 0;

    exp_arbiter #(.N(N), .XW(XW), .RW(RW), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_x(req_x),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
        .busy(busy), .grant_id(grant_id), .exp_start(exp_start), .exp_x(exp_x),
        .exp_done(exp_done), .exp_result(exp_result)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end
    initial begin #1000000; $display("FAIL global_timeout"); $fatal(1); end

    function automatic logic [RW-1:0] f(input logic [XW-1:0] x);
        return RW'($rtoi($exp(real'(x) / 65536.0) * 65536.0));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total++;
        $display("FAIL %s: event not expected or not reached", name);
    endtask

    // exponential core: drops done on start, computes for core_lat cycles unless hung
    initial begin
        int cnt = 0;
        logic [XW-1:0] cx = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_done = 1'b1;
                cnt = 0;
            end else if (exp_start) begin
                cx = exp_x;
                core_lat = $urandom_range(2, 7);
                cnt = core_lat;
                exp_done = 1'b0;
                exp_result = RW'($urandom);
            end else if (cnt > 0 && !hang) begin
                cnt--;
                if (cnt == 0) begin
                    exp_done = 1'b1;
                    exp_result = f(cx);
                end
            end
        end
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (exp_start) begin
            n_start++;
            start_cyc = cyc;
            if (sb.size() == 0) fail_now("start_unexpected");
            else begin
                chk("start_grant", 32'(grant_id), 32'(sb[0].id));
                chk("start_x", 32'(exp_x), 32'(sb[0].x));
                chk("start_busy", 32'(busy), 32'd1);
            end
        end
        if (resp_valid != '0) begin
            n_resp++;
            if (sb.size() == 0) fail_now("resp_unexpected");
            else begin
                e = sb.pop_front();
                chk("resp_onehot", 32'(resp_valid), 32'(1) << e.id);
                chk("resp_data", 32'(resp_data), 32'(e.data));
                chk("resp_err", 32'(resp_err), 32'(e.err));
                chk("resp_latency", cyc - start_cyc, e.err ? TMO + 3 : core_lat + 1);
            end
        end
    end

    task automatic push_jobs(input logic [N-1:0] mask, input logic [N*XW-1:0] xv, input int hold_n, input bit hg, output int jobs);
        logic [N-1:0] rem = mask;
        int id;
        exp_t e;
        jobs = hold_n > 0 ? hold_n : $countones(mask);
        for (int j = 0; j < jobs; j++) begin
            id = 0;
            for (int k = N - 1; k >= 0; k--) if (rem[(ptr_m + k) % N]) id = (ptr_m + k) % N;
            e.id = id;
            e.x = xv[id*XW +: XW];
            e.err = hg;
            e.data = hg ? '0 : f(e.x);
            sb.push_back(e);
            ptr_m = (id + 1) % N;
            if (hold_n == 0) rem[id] = 1'b0;
        end
    endtask

    task automatic run_batch(input logic [N-1:0] mask, input logic [N*XW-1:0] xv, input int hold_n, input bit early, input bit hg);
        int jobs, got = 0, since = -1;
        hang = hg;
        req_x = xv;
        push_jobs(mask, xv, hold_n, hg, jobs);
        @(negedge clk);
        req = mask;
        for (int c = 0; c < 400 && got < jobs; c++) begin
            @(negedge clk);
            if (exp_start) since = 0; else if (since >= 0) since++;
            if (early && since == 2) req = '0;
            if (resp_valid != '0) begin
                got++;
                if (hold_n == 0) req &= ~resp_valid;
                else if (got == hold_n) req = '0;
            end
        end
        if (got < jobs) begin
            fail_now("batch_timeout");
            req = '0;
            sb.delete();
        end
        hang = 0;
    endtask

    initial begin
        int jobs;
        logic [N-1:0] m;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(resp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(exp_start), 0);
        chk("rst_data", 32'(resp_data), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_x", 32'(exp_x), 0);
        rst = 1;
        run_batch(4'b1111, {16'hC000, 16'h8000, 16'h4000, 16'h0000}, 5, 0, 0);
        run_batch(4'b0001, {48'h123456789ABC, 16'h0000}, 0, 0, 0);
        run_batch(4'b0100, {$urandom, $urandom}, 0, 0, 0);
        run_batch(4'b0101, {$urandom, $urandom}, 0, 0, 0);
        run_batch(4'b0010, {$urandom, $urandom}, 0, 0, 1);
        run_batch(4'b0010, {$urandom, $urandom}, 0, 0, 0);
        run_batch(4'b0010, {$urandom, $urandom}, 0, 1, 0);
        // job in flight on requester 3, then reset while the core hangs in WAIT
        hang = 1;
        req_x = {$urandom, $urandom};
        push_jobs(4'b1000, req_x, 0, 1, jobs);
        @(negedge clk);
        req = 4'b1000;
        for (int c = 0; c < 20 && !exp_start; c++) @(negedge clk);
        if (!exp_start) fail_now("reset_job_start");
        repeat (5) @(negedge clk);
        chk("wait_busy", 32'(busy), 1);
        sb.delete();
        rst = 0;
        req = '0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(resp_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_grant", 32'(grant_id), 0);
        chk("mid_rst_data", 32'(resp_data), 0);
        chk("mid_rst_err", 32'(resp_err), 0);
        chk("mid_rst_x", 32'(exp_x), 0);
        rst = 1;
        hang = 0;
        ptr_m = 0;
        repeat (3) @(negedge clk);
        run_batch(4'b1111, {$urandom, $urandom}, 0, 0, 0);
        for (int b = 0; b < 25; b++) begin
            m = N'($urandom_range(1, 2**N - 1));
            run_batch(m, {$urandom, $urandom}, ($urandom_range(0, 3) == 0) ? $urandom_range(2, 6) : 0, 0, $urandom_range(0, 5) == 0);
        end
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("start_count", n_start, n_resp + 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/exp_arbiter.md
# exp_arbiter

Round-robin scheduler that shares one `exponential` core among N requesters. It accepts per-requester operands, sequences the core's start/done handshake, and returns each 18-bit result to the requester that owns it. A watchdog flags a core that never completes. It sits between the requester-side logic and a single `exponential` instance.

## Interface
- `N`, default 4: number of requesters (2–8).
- `XW`, default 16: operand width (fraction bits of x).
- `RW`, default 18: result width ({intpart[1:0], fracpart[15:0]}).
- `TMO`, default 1023: maximum WAIT cycles before timeout.
- `clk` input, 1 bit: the one clock.
- `rst` input, 1 bit: reset. Synchronous and active-low; takes effect when low at a `clk` posedge.
- `req` input, N bits: request per requester; must be held with a stable operand until that requester's `resp_valid` bit is seen.
- `req_x` input, N*XW bits: operands; slot i is bits [i*XW +: XW].
- `resp_valid` output, N bits: one-hot, one-cycle pulse marking completion for a requester.
- `resp_data` output, RW bits: result for the pulsed requester; held until the next completion.
- `resp_err` output, 1 bit: high with `resp_valid` when the job timed out.
- `busy` output, 1 bit: high in every state except IDLE.
- `grant_id` output, $clog2(N) bits: index of the requester currently being served.
- `exp_start` output, 1 bit: drives the core's `start`.
- `exp_x` output, XW bits: drives the core's `x`.
- `exp_done` input, 1 bit: core `done` (high when the core is idle).
- `exp_result` input, RW bits: core {intpart, fracpart}.

## Operation
- FSM states: IDLE, ISSUE, ARM, WAIT, RESP.
- IDLE
  - If `req` is nonzero, the winner is the first set bit at or after `ptr`, searching upward with wrap.
  - Latch `grant_id` and `req_x[winner]` into `x_q`, then go to ISSUE.
  - If `req` is zero, stay in IDLE.
- ISSUE: `exp_start`=1 and `exp_x`=`x_q` for exactly one cycle, then go to ARM.
- ARM: `exp_start`=0 and `exp_done` is ignored, because the core drops `done` only after sampling start. Clear `tmo_cnt` and go to WAIT.
- WAIT
  - On `exp_done`=1: latch `exp_result` into `resp_data`, set `resp_err`=0, go to RESP.
  - Otherwise `tmo_cnt` increments.
  - If `tmo_cnt`==TMO, set `resp_data`=0 and `resp_err`=1, then go to RESP.
- RESP
  - Assert `resp_valid[grant_id]` for one cycle.
  - Set `ptr` = (`grant_id`+1) mod N, then go to IDLE.
- `exp_x` is driven with `x_q` in all states, so the core sees a stable operand.
- If `req[grant_id]` drops mid-service, the job still completes and the response still pulses.
- A requester still asserting `req` in the IDLE cycle after its response is treated as a new request. The rotated `ptr` lets other requesters win first.
- Requesters other than the one being served are not sampled outside IDLE.

## Timing
- Reset values: state=IDLE, `ptr`=0, `x_q`=0, `tmo_cnt`=0, `grant_id`=0, `resp_data`=0, `resp_err`=0, `resp_valid`=0, `exp_start`=0, `busy`=0.
- `req` high in IDLE at cycle t gives `exp_start` high at t+1, while the FSM is in ISSUE.
- `exp_done` seen high in WAIT at cycle w gives `resp_valid` at w+1.
- Overhead beyond the core's compute time is 4 cycles from request to response.
- Back-to-back throughput: one job per (core time + 4) cycles. The cycle following RESP is always IDLE.
- Timeout: `resp_valid` with `resp_err`=1 arrives exactly TMO+1 cycles after entering WAIT with `exp_done` held low.
- Reset low in any state returns everything to its reset values at the next edge. Any in-flight job is dropped with no response.
- `tmo_cnt` width is $clog2(TMO+1) and it saturates at TMO.

## Structure
- Package `exp_arb_pkg` holds:
  - the state enum `arb_state_t` (IDLE, ISSUE, ARM, WAIT, RESP);
  - default width localparams XW_D=16 and RW_D=18.
- Sub-module `rr_picker`, combinational.
  - Inputs: `req[N]` and `ptr`.
  - Outputs: `any` and `winner` index, using a double-width masked priority search.
- The FSM, registers and watchdog live in `exp_arbiter`.

## Test plan
- Single request: `req`=4'b0001 with x=16'h0000 → `exp_start` pulses once. Then `resp_valid`=4'b0001 with `resp_data`=18'h10000 (e^0 = 1.0) and `resp_err`=0.
- Contention: `req`=4'b1111 held after each response, operands 0x0000/0x4000/0x8000/0xC000 → service order 0,1,2,3,0. `resp_data` matches the core model per slot.
- Pointer rotation: serve requester 2, then set `req`=4'b0101 → requester 2 is served again only after requester 0, since `ptr`=3 wraps to 0.
- Timeout: core model holds `exp_done`=0 after start, TMO=15 → `resp_valid[grant_id]` with `resp_err`=1 and `resp_data`=0 exactly 16 cycles after WAIT entry. The next request is then serviced normally.
- Mid-job reset: `rst`=0 during WAIT → next edge shows state IDLE, all outputs 0 and `ptr`=0, with no `resp_valid` pulse.
- Request withdrawn: `req[1]` drops in WAIT → `resp_valid`=4'b0010 still pulses. `exp_start` shows exactly one pulse per granted job.
